// File: rtl/keypad_scanner.sv
// ROWS x COLS matrix scanner with per-key debounce, n-key rollover and a FWFT press/release event FIFO.
// Optional auto-repeat of the most recently pressed key is enabled with `define KEYPAD_AUTOREPEAT_EN.
module keypad_scanner #(
    parameter int ROWS           = 4,
    parameter int COLS           = 4,
    parameter int SCAN_DIV       = 1200,
    parameter int DEBOUNCE_SCANS = 3,
    parameter int FIFO_DEPTH     = 4,
    parameter int REPEAT_DELAY   = 50,
    parameter int REPEAT_PERIOD  = 10,
    localparam int KW            = $clog2(ROWS*COLS)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [COLS-1:0]      col_inputs,
    output logic [ROWS-1:0]      row_outputs,
    output logic                 ev_valid,
    input  logic                 ev_ready,
    output logic [KW-1:0]        ev_key,
    output logic                 ev_press,
    output logic                 ev_repeat,
    output logic [ROWS*COLS-1:0] key_state,
    output logic                 overflow,
    input  logic                 ovf_clr
);

    localparam int NK = ROWS*COLS;
    localparam int DW = $clog2(SCAN_DIV);
    localparam int RW = $clog2(ROWS);
    localparam int CW = $clog2(COLS);
    localparam int PW = $clog2(FIFO_DEPTH);

    if (ROWS < 2 || ROWS > 8 || COLS < 2 || COLS > 8 || SCAN_DIV < COLS+4 ||
        DEBOUNCE_SCANS < 1 || DEBOUNCE_SCANS > 15 || FIFO_DEPTH < 2 ||
        (FIFO_DEPTH & (FIFO_DEPTH-1)) != 0 || REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_param_check
        $error("keypad_scanner: illegal parameter set");
    end

    typedef enum logic [1:0] {PH_DRIVE, PH_SETTLE, PH_READ} phase_e;

    logic [COLS-1:0] col_meta_q, col_sync_q;
    logic [DW-1:0]   div_q;
    phase_e          phase_q;
    logic [RW-1:0]   row_q;
    logic [ROWS-1:0] row_out_q;
    logic [3:0]      cnt_q [NK];
    logic [NK-1:0]   state_q;

    logic [KW-1:0]   fkey_q   [FIFO_DEPTH];
    logic            fpress_q [FIFO_DEPTH];
    logic [PW-1:0]   rd_q, wr_q;
    logic [PW:0]     count_q, count_d;
    logic            ovf_q;

    logic            rd_en, raw, commit;
    logic [CW-1:0]   col;
    logic [KW-1:0]   key_idx;
    logic [3:0]      cnt_inc;
    logic            push_v, push_press, push_rep, push_ok, pop, full, drop;
    logic [KW-1:0]   push_key;

`ifdef KEYPAD_AUTOREPEAT_EN
    localparam int TMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int TW   = $clog2(TMAX+1);
    logic            trk_valid_q, trk_first_q, trk_arm_q;
    logic [KW-1:0]   trk_key_q;
    logic [TW-1:0]   trk_cnt_q, trk_next;
    logic [RW-1:0]   trk_row;
    logic            rep_slot, rep_fire;
    logic            frep_q [FIFO_DEPTH];
`endif

    always_comb begin
        rd_en      = (phase_q == PH_READ) && (div_q < DW'(COLS));
        col        = div_q[CW-1:0];
        key_idx    = KW'(int'(row_q)*COLS + int'(col));
        raw        = ~col_sync_q[col];
        cnt_inc    = cnt_q[key_idx] + 4'd1;
        commit     = rd_en && (raw != state_q[key_idx]) && (cnt_inc == 4'(DEBOUNCE_SCANS));
        push_v     = commit;
        push_key   = key_idx;
        push_press = raw;
        push_rep   = 1'b0;
`ifdef KEYPAD_AUTOREPEAT_EN
        trk_row  = RW'(int'(trk_key_q) / COLS);
        trk_next = trk_cnt_q + TW'(1);
        rep_slot = trk_valid_q && (phase_q == PH_READ) && (div_q == DW'(COLS)) && (row_q == trk_row);
        rep_fire = rep_slot && trk_arm_q &&
                   (trk_first_q ? (trk_next == TW'(REPEAT_DELAY)) : (trk_next == TW'(REPEAT_PERIOD)));
        // Repeat slot (divider = COLS) never coincides with a column evaluation.
        if (rep_fire) begin
            push_v     = 1'b1;
            push_key   = trk_key_q;
            push_press = 1'b1;
            push_rep   = 1'b1;
        end
`endif
        pop     = ev_valid && ev_ready;
        full    = (count_q == (PW+1)'(FIFO_DEPTH));
        push_ok = push_v && (!full || pop);
        drop    = push_v && full && !pop;
        count_d = count_q + (PW+1)'(push_ok) - (PW+1)'(pop);
    end

    always_ff @(posedge clk) begin
        col_meta_q <= col_inputs;
        col_sync_q <= col_meta_q;
        if (push_ok) begin
            fkey_q[wr_q]   <= push_key;
            fpress_q[wr_q] <= push_press;
`ifdef KEYPAD_AUTOREPEAT_EN
            frep_q[wr_q]   <= push_rep;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            div_q     <= '0;
            phase_q   <= PH_DRIVE;
            row_q     <= '0;
            row_out_q <= '1;
            state_q   <= '0;
            for (int i = 0; i < NK; i++) cnt_q[i] <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            count_q   <= '0;
            ovf_q     <= 1'b0;
        end else begin
            if (div_q == DW'(SCAN_DIV-1)) begin
                div_q <= '0;
                case (phase_q)
                    PH_DRIVE:  phase_q <= PH_SETTLE;
                    PH_SETTLE: phase_q <= PH_READ;
                    default: begin
                        phase_q <= PH_DRIVE;
                        row_q   <= (row_q == RW'(ROWS-1)) ? '0 : row_q + RW'(1);
                    end
                endcase
            end else begin
                div_q <= div_q + DW'(1);
            end
            if (phase_q == PH_DRIVE) row_out_q <= ~({{(ROWS-1){1'b0}}, 1'b1} << row_q);

            if (rd_en) begin
                if (raw == state_q[key_idx] || commit) cnt_q[key_idx] <= '0;
                else                                   cnt_q[key_idx] <= cnt_inc;
                if (commit) state_q[key_idx] <= raw;
            end

            if (push_ok) wr_q <= wr_q + PW'(1);
            if (pop)     rd_q <= rd_q + PW'(1);
            count_q <= count_d;
            // A drop in the same cycle as a clear leaves the flag set.
            if (drop)         ovf_q <= 1'b1;
            else if (ovf_clr) ovf_q <= 1'b0;
        end
    end

`ifdef KEYPAD_AUTOREPEAT_EN
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            trk_valid_q <= 1'b0;
            trk_first_q <= 1'b0;
            trk_arm_q   <= 1'b0;
            trk_key_q   <= '0;
            trk_cnt_q   <= '0;
        end else if (commit && raw) begin
            trk_valid_q <= 1'b1;
            trk_first_q <= 1'b1;
            trk_arm_q   <= 1'b0;
            trk_key_q   <= key_idx;
            trk_cnt_q   <= '0;
        end else if (commit && (key_idx == trk_key_q)) begin
            trk_valid_q <= 1'b0;
        end else if (rep_slot) begin
            // The slot in the press frame itself only arms the tracker.
            if (!trk_arm_q) begin
                trk_arm_q <= 1'b1;
            end else if (rep_fire) begin
                trk_cnt_q   <= '0;
                trk_first_q <= 1'b0;
            end else begin
                trk_cnt_q <= trk_next;
            end
        end
    end
    assign ev_repeat = ev_valid ? frep_q[rd_q] : 1'b0;
`else
    assign ev_repeat = 1'b0;
`endif

    assign row_outputs = row_out_q;
    assign key_state   = state_q;
    assign overflow    = ovf_q;
    assign ev_valid    = (count_q != '0);
    assign ev_key      = ev_valid ? fkey_q[rd_q]   : '0;
    assign ev_press    = ev_valid ? fpress_q[rd_q] : 1'b0;

endmodule
